// File: rtl/ps2_pkg.sv
// Shared constants, types and frame helpers for the PS/2 keyboard transmitter.
package ps2_pkg;
   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned STOP_IDX   = 10;
   localparam int unsigned BIDX_W     = 4;

   typedef enum logic [1:0] {IDLE, HI, LO, GAP} ps2_state_e;
   typedef logic [7:0] scancode_t;

   // Wire order: start is bit 0, stop is bit 10.
   typedef struct packed {
      logic      stop;
      logic      parity;
      scancode_t data;
      logic      start;
   } ps2_frame_t;

   function automatic logic odd_parity(input scancode_t data);
      return ~^data;
   endfunction

   function automatic ps2_frame_t build_frame(input scancode_t data);
      ps2_frame_t f;
      f.stop   = 1'b1;
      f.parity = odd_parity(data);
      f.data   = data;
      f.start  = 1'b0;
      return f;
   endfunction
endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Scancode write channel into the PS/2 transmitter queue.
interface ps2_kbd_tx_if;
   import ps2_pkg::*;

   logic      wr_valid;
   scancode_t wr_data;
   logic      wr_ready;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/ps2_fifo.sv
// Synchronous scancode FIFO; ready is registered and stays low for the cycle a full FIFO pops.
module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       push,
   input  scancode_t                  wdata,
   input  logic                       pop,
   output scancode_t                  rdata_c,
   output logic                       ready,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   scancode_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [LVL_W-1:0] level_d;

   always_comb begin
      push_ok = push && ready;
      pop_ok  = pop && (level != '0);
      level_d = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
   end

   assign rdata_c = mem[rd_ptr];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ready  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_d;
         ready <= (level_d != LVL_W'(DEPTH));
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scancodes and serialises 11-bit frames,
// aborting and later resending a frame when the host inhibits before the stop bit.
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 25_000_000,
   parameter int unsigned PS2_FREQ_HZ = 10_000,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned GAP_HALVES  = 2
) (
   input  logic                            clock,
   input  logic                            resetn,
   ps2_kbd_tx_if.slave                     wr,
   input  logic                            ps2_inhibit,
   output logic                            ps2_clk,
   output logic                            ps2_dat,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
   localparam int unsigned HALF     = CLK_FREQ_HZ / (2 * PS2_FREQ_HZ);
   localparam int unsigned CNT_W    = $clog2(HALF);
   localparam int unsigned GAP_CYC  = GAP_HALVES * HALF;
   localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
   localparam int unsigned GAP_W    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
   localparam int unsigned SH_W     = FRAME_BITS - 1;

   ps2_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [BIDX_W-1:0] bidx_q, bidx_d;
   logic [SH_W-1:0]   shreg_q, shreg_d;
   logic              pending_q;
   logic              clk_d, dat_d, busy_d;
   logic              pop_c, abort_c;
   scancode_t         head_c;
   ps2_frame_t        frame_c;

   ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .push    (wr.wr_valid),
      .wdata   (wr.wr_data),
      .pop     (pop_c),
      .rdata_c (head_c),
      .ready   (wr.wr_ready),
      .level   (fifo_level)
   );

   // State, counters and registered line outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= GAP;
         cnt_q     <= '0;
         gap_q     <= '0;
         bidx_q    <= '0;
         shreg_q   <= '0;
         pending_q <= 1'b0;
         ps2_clk   <= 1'b1;
         ps2_dat   <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         bidx_q    <= bidx_d;
         shreg_q   <= shreg_d;
         pending_q <= (fifo_level != '0);
         ps2_clk   <= clk_d;
         ps2_dat   <= dat_d;
         busy      <= busy_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      bidx_d  = bidx_q;
      shreg_d = shreg_q;
      clk_d   = ps2_clk;
      dat_d   = ps2_dat;
      pop_c   = 1'b0;
      frame_c = build_frame(head_c);
      abort_c = ps2_inhibit && (bidx_q != BIDX_W'(STOP_IDX));

      unique case (state_q)
         IDLE: begin
            clk_d = 1'b1;
            dat_d = 1'b1;
            if (pending_q && !ps2_inhibit) begin
               state_d = HI;
               cnt_d   = CNT_W'(HALF - 1);
               bidx_d  = '0;
               dat_d   = frame_c.start;
               shreg_d = frame_c[FRAME_BITS-1:1];
            end
         end
         HI: begin
            if (abort_c) begin
               state_d = GAP;
               gap_d   = '0;
               clk_d   = 1'b1;
               dat_d   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = LO;
               cnt_d   = CNT_W'(HALF - 1);
               clk_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LO: begin
            if (abort_c) begin
               state_d = GAP;
               gap_d   = '0;
               clk_d   = 1'b1;
               dat_d   = 1'b1;
            end else if (cnt_q == '0) begin
               clk_d = 1'b1;
               if (bidx_q == BIDX_W'(STOP_IDX)) begin
                  pop_c   = 1'b1;
                  state_d = GAP;
                  gap_d   = '0;
                  dat_d   = 1'b1;
               end else begin
                  state_d = HI;
                  cnt_d   = CNT_W'(HALF - 1);
                  bidx_d  = bidx_q + BIDX_W'(1);
                  dat_d   = shreg_q[0];
                  shreg_d = {1'b1, shreg_q[SH_W-1:1]};
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            clk_d = 1'b1;
            dat_d = 1'b1;
            if (ps2_inhibit) begin
               gap_d = '0;
            end else if (gap_q == GAP_W'(GAP_LAST)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = GAP;
      endcase

      busy_d = (state_d == HI) || (state_d == LO);
   end
endmodule
